// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: single-entry issue buffer between decode and execution.
// Holds one decoded instruction, checks it against the register in-use
// scoreboard for RAW/WAW hazards and issues it only when it is hazard free.
// After reset or flush it drives the scoreboard clear for CLEAR_CYCLES cycles
// before accepting anything.
//
// Handshakes (decode side and issue side) are strict valid/ready: a transfer
// happens in a cycle where valid && ready are both high at the rising edge.
// Valid never depends on ready. Once raised, iss_valid_o and the issue fields
// hold stable until the transfer completes. The only exception is gc_flush_i,
// which withdraws the buffered instruction.
module issue_hazard_ctrl #(
    parameter int unsigned CLEAR_CYCLES = 32,
    parameter int unsigned ID_W         = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            gc_flush_i,
    // decode side
    input  logic            dec_valid_i,
    output logic            dec_ready_o,
    input  logic [4:0]      dec_rs1_addr_i,
    input  logic [4:0]      dec_rs2_addr_i,
    input  logic [4:0]      dec_rd_addr_i,
    input  logic            dec_uses_rs1_i,
    input  logic            dec_uses_rs2_i,
    input  logic            dec_uses_rd_i,
    input  logic [ID_W-1:0] dec_id_i,
    // scoreboard read ports (combinational data return)
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_inuse_addr_o,
    input  logic            rs1_inuse_i,
    input  logic            rs2_inuse_i,
    input  logic            rd_inuse_i,
    // writeback retire snoop
    input  logic            retired_i,
    input  logic [4:0]      retired_rd_addr_i,
    // scoreboard update / clear
    output logic            issued_o,
    output logic [4:0]      issued_rd_addr_o,
    output logic            clr_o,
    // issue side
    output logic            iss_valid_o,
    input  logic            iss_ready_i,
    output logic [ID_W-1:0] iss_id_o,
    output logic [4:0]      iss_rd_addr_o,
    output logic            init_done_o,
    // debug visibility
    output logic            dbg_state_o,
    output logic            dbg_buf_valid_o
);

    localparam int unsigned CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            clr_q;
    logic            init_done_q;

    logic            buf_valid_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic            uses_rs1_q;
    logic            uses_rs2_q;
    logic            uses_rd_q;
    logic [ID_W-1:0] id_q;

    logic run;
    logic byp_rs1;
    logic byp_rs2;
    logic byp_rd;
    logic hz_rs1;
    logic hz_rs2;
    logic hz_rd;
    logic iss_valid;
    logic fire;
    logic dec_ready;
    logic accept;

    assign run = (state_q == ST_RUN);

    // A retire in the same cycle releases the register early (bypass); the
    // snoop is only trusted once the scoreboard clear has finished.
    assign byp_rs1 = run && retired_i && (retired_rd_addr_i == rs1_q);
    assign byp_rs2 = run && retired_i && (retired_rd_addr_i == rs2_q);
    assign byp_rd  = run && retired_i && (retired_rd_addr_i == rd_q);

    // x0 is never a hazard source.
    assign hz_rs1 = uses_rs1_q && (rs1_q != 5'd0) && rs1_inuse_i && !byp_rs1;
    assign hz_rs2 = uses_rs2_q && (rs2_q != 5'd0) && rs2_inuse_i && !byp_rs2;
    assign hz_rd  = uses_rd_q  && (rd_q  != 5'd0) && rd_inuse_i  && !byp_rd;

    // Flush withdraws the offer in the same cycle so no fire can coincide.
    assign iss_valid = run && buf_valid_q && !hz_rs1 && !hz_rs2 && !hz_rd && !gc_flush_i;
    assign fire      = iss_valid && iss_ready_i;
    assign dec_ready = run && (!buf_valid_q || fire) && !gc_flush_i;
    assign accept    = dec_valid_i && dec_ready;

    assign dec_ready_o      = dec_ready;
    assign iss_valid_o      = iss_valid;
    assign iss_id_o         = id_q;
    assign iss_rd_addr_o    = rd_q;
    assign rs1_addr_o       = rs1_q;
    assign rs2_addr_o       = rs2_q;
    assign rd_inuse_addr_o  = rd_q;
    assign issued_o         = fire && uses_rd_q && (rd_q != 5'd0);
    assign issued_rd_addr_o = rd_q;
    assign clr_o            = clr_q;
    assign init_done_o      = init_done_q;
    assign dbg_state_o      = state_q;
    assign dbg_buf_valid_o  = buf_valid_q;

    // Clear/run sequencer with registered clr and init_done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            clr_q       <= 1'b1;
            init_done_q <= 1'b0;
        end else if (gc_flush_i) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            clr_q       <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= '0;
                        clr_q       <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q     <= ST_RUN;
                    clr_q       <= 1'b0;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_CLEAR;
                    cnt_q       <= '0;
                    clr_q       <= 1'b1;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry buffer: flush drops it, accept refills it, fire empties it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            uses_rs1_q  <= 1'b0;
            uses_rs2_q  <= 1'b0;
            uses_rd_q   <= 1'b0;
            id_q        <= '0;
        end else if (gc_flush_i) begin
            buf_valid_q <= 1'b0;
        end else if (accept) begin
            buf_valid_q <= 1'b1;
            rs1_q       <= dec_rs1_addr_i;
            rs2_q       <= dec_rs2_addr_i;
            rd_q        <= dec_rd_addr_i;
            uses_rs1_q  <= dec_uses_rs1_i;
            uses_rs2_q  <= dec_uses_rs2_i;
            uses_rd_q   <= dec_uses_rd_i;
            id_q        <= dec_id_i;
        end else if (fire) begin
            buf_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Testbench for issue_hazard_ctrl: directed vectors with a behavioural
// register scoreboard and an expected-issue queue.
module tb_issue_hazard_ctrl;

    localparam int ID_W = 3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic            gc_flush;
    logic            dec_valid;
    logic            dec_ready;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_u1, dec_u2, dec_urd;
    logic [ID_W-1:0] dec_id;
    logic [4:0]      rs1_addr, rs2_addr, rd_inuse_addr;
    logic            rs1_inuse, rs2_inuse, rd_inuse;
    logic            retired;
    logic [4:0]      retired_rd;
    logic            issued;
    logic [4:0]      issued_rd;
    logic            clr;
    logic            iss_valid;
    logic            iss_ready;
    logic [ID_W-1:0] iss_id;
    logic [4:0]      iss_rd;
    logic            init_done;
    logic            dbg_state;
    logic            dbg_buf_valid;

    issue_hazard_ctrl #(.CLEAR_CYCLES(32), .ID_W(ID_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .gc_flush_i       (gc_flush),
        .dec_valid_i      (dec_valid),
        .dec_ready_o      (dec_ready),
        .dec_rs1_addr_i   (dec_rs1),
        .dec_rs2_addr_i   (dec_rs2),
        .dec_rd_addr_i    (dec_rd),
        .dec_uses_rs1_i   (dec_u1),
        .dec_uses_rs2_i   (dec_u2),
        .dec_uses_rd_i    (dec_urd),
        .dec_id_i         (dec_id),
        .rs1_addr_o       (rs1_addr),
        .rs2_addr_o       (rs2_addr),
        .rd_inuse_addr_o  (rd_inuse_addr),
        .rs1_inuse_i      (rs1_inuse),
        .rs2_inuse_i      (rs2_inuse),
        .rd_inuse_i       (rd_inuse),
        .retired_i        (retired),
        .retired_rd_addr_i(retired_rd),
        .issued_o         (issued),
        .issued_rd_addr_o (issued_rd),
        .clr_o            (clr),
        .iss_valid_o      (iss_valid),
        .iss_ready_i      (iss_ready),
        .iss_id_o         (iss_id),
        .iss_rd_addr_o    (iss_rd),
        .init_done_o      (init_done),
        .dbg_state_o      (dbg_state),
        .dbg_buf_valid_o  (dbg_buf_valid)
    );

    // ---------------- register in-use scoreboard model ----------------
    logic [31:0] sb;
    assign rs1_inuse = sb[rs1_addr];
    assign rs2_inuse = sb[rs2_addr];
    assign rd_inuse  = sb[rd_inuse_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else if (clr) begin
            sb <= '0;
        end else begin
            if (retired) sb[retired_rd] <= 1'b0;
            if (issued && issued_rd != 5'd0) sb[issued_rd] <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // expected fires in order: {issued, issued_rd, iss_id}
    logic [8:0] exp_q[$];

    function automatic logic [8:0] pack(input logic iss, input logic [4:0] rd, input logic [2:0] id);
        return {iss, rd, id};
    endfunction

    always @(negedge clk) begin
        if (rst_n && iss_valid && iss_ready) begin
            if (exp_q.size() == 0) check("unexpected_fire", {23'd0, issued, issued_rd, iss_id}, 32'h1ff);
            else check("fire", {23'd0, issued, issued_rd, iss_id}, {23'd0, exp_q.pop_front()});
        end
        if (rst_n && issued && !(iss_valid && iss_ready))
            check("issued_without_fire", 32'd1, 32'd0);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dec(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic urd, input logic [2:0] id);
        dec_valid = v;
        dec_rs1 = rs1; dec_u1 = u1;
        dec_rs2 = rs2; dec_u2 = u2;
        dec_rd  = rd;  dec_urd = urd;
        dec_id  = id;
    endtask

    task automatic idle_dec();
        drive_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    endtask

    task automatic retire(input logic [4:0] addr);
        retired = 1'b1;
        retired_rd = addr;
        step();
        retired = 1'b0;
        retired_rd = 5'd0;
    endtask

    // Observes a clear sequence starting in the current cycle (index 0):
    // counts clr-high cycles and finds the first dec_ready cycle.
    task automatic measure_clear(input string tag);
        int clr_cycles = 0;
        int first_ready = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (clr) clr_cycles++;
            if (dec_ready && first_ready < 0) first_ready = i;
            @(posedge clk);
            #1;
        end
        check({tag, "_clr_cycles"}, clr_cycles, 32);
        check({tag, "_first_ready"}, first_ready, 32);
        check({tag, "_init_done"}, {31'd0, init_done}, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        gc_flush = 1'b0;
        iss_ready = 1'b1;
        retired = 1'b0;
        retired_rd = 5'd0;
        idle_dec();

        // reset state
        step();
        step();
        check("rst_clr", {31'd0, clr}, 1);
        check("rst_init_done", {31'd0, init_done}, 0);
        check("rst_dec_ready", {31'd0, dec_ready}, 0);
        check("rst_iss_valid", {31'd0, iss_valid}, 0);
        check("rst_issued", {31'd0, issued}, 0);
        check("rst_buf_valid", {31'd0, dbg_buf_valid}, 0);

        // release reset and time the clear sequence
        rst_n = 1'b1;
        measure_clear("reset");

        // back-to-back independent: rd=x1 then rd=x2
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 3'd1);
        exp_q.push_back(pack(1'b1, 5'd1, 3'd1));
        #1 check("b2b_ready0", {31'd0, dec_ready}, 1);
        step();
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 3'd2);
        exp_q.push_back(pack(1'b1, 5'd2, 3'd2));
        #1 check("b2b_fire1", {31'd0, iss_valid, dec_ready, issued}, 32'h7);
        step();
        idle_dec();
        #1 check("b2b_fire2", {26'd0, issued, issued_rd}, {26'd0, 1'b1, 5'd2});
        step();
        check("b2b_empty", {31'd0, iss_valid}, 0);
        retire(5'd1);
        retire(5'd2);

        // RAW on x5 with retire bypass
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd3);
        exp_q.push_back(pack(1'b1, 5'd5, 3'd3));
        step();
        drive_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd4);
        exp_q.push_back(pack(1'b1, 5'd6, 3'd4));
        step();
        idle_dec();
        #1 check("raw_stall0", {31'd0, iss_valid}, 0);
        step();
        check("raw_stall1", {31'd0, iss_valid}, 0);
        retired = 1'b1;
        retired_rd = 5'd5;
        #1 check("raw_bypass_fire", {31'd0, iss_valid}, 1);
        step();
        retired = 1'b0;
        check("raw_empty", {31'd0, iss_valid}, 0);
        retire(5'd6);

        // WAW on x3, then a write to x0
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd5);
        exp_q.push_back(pack(1'b1, 5'd3, 3'd5));
        step();
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd6);
        exp_q.push_back(pack(1'b1, 5'd3, 3'd6));
        step();
        idle_dec();
        #1 check("waw_stall", {31'd0, iss_valid}, 0);
        step();
        retired = 1'b1;
        retired_rd = 5'd3;
        #1 check("waw_bypass_fire", {31'd0, iss_valid}, 1);
        step();
        retired = 1'b0;
        retire(5'd3);
        drive_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd7);
        exp_q.push_back(pack(1'b0, 5'd0, 3'd7));
        step();
        idle_dec();
        #1 check("x0_fire", {30'd0, iss_valid, issued}, 32'h2);
        step();

        // backpressure: 4 cycles not ready
        iss_ready = 1'b0;
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd3);
        exp_q.push_back(pack(1'b1, 5'd7, 3'd3));
        step();
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd4);
        exp_q.push_back(pack(1'b1, 5'd8, 3'd4));
        for (int i = 0; i < 4; i++) begin
            #1 check("bp_hold", {28'd0, iss_valid, dec_ready, iss_id}, {28'd0, 1'b1, 1'b0, 3'd3});
            step();
        end
        iss_ready = 1'b1;
        #1 check("bp_release", {31'd0, dec_ready}, 1);
        step();
        idle_dec();
        #1 check("bp_second", {29'd0, iss_id}, 3'd4);
        step();
        retire(5'd7);
        retire(5'd8);

        // flush while a dependent instruction stalls
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd1);
        exp_q.push_back(pack(1'b1, 5'd9, 3'd1));
        step();
        drive_dec(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 1'b1, 3'd2);
        step();
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 3'd5);
        #1 check("flush_pre_stall", {30'd0, iss_valid, dbg_buf_valid}, 32'h1);
        gc_flush = 1'b1;
        #1 check("flush_dec_ready", {31'd0, dec_ready}, 0);
        step();
        gc_flush = 1'b0;
        idle_dec();
        check("flush_buf_clear", {29'd0, dbg_buf_valid, clr, dbg_state}, 32'h2);
        measure_clear("flush");

        // async reset in the middle of a clear restarts the count
        gc_flush = 1'b1;
        step();
        gc_flush = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #2 rst_n = 1'b0;
        #1 check("async_rst_clr", {30'd0, clr, init_done}, 32'h2);
        step();
        rst_n = 1'b1;
        measure_clear("rst_mid_clear");

        // flush coincident with a ready-to-fire instruction
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd6);
        step();
        idle_dec();
        gc_flush = 1'b1;
        #1 check("flush_vs_fire", {30'd0, iss_valid, issued}, 0);
        step();
        gc_flush = 1'b0;
        measure_clear("flush2");

        // one more instruction after recovery
        drive_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd5);
        exp_q.push_back(pack(1'b1, 5'd4, 3'd5));
        step();
        idle_dec();
        step();
        step();

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_hazard_ctrl.md
# issue_hazard_ctrl

Single-entry issue buffer between decode and the execution units. It holds one decoded instruction and checks its source and destination registers against the register in-use scoreboard. It issues the instruction only when no RAW or WAW hazard exists. It also sequences the scoreboard clear after reset or flush by asserting `clr` for `CLEAR_CYCLES` cycles before accepting any instruction.

## Interface
- `CLEAR_CYCLES`, 32, number of cycles `clr` is held; must be ≥ number of architectural registers (32).
- `ID_W`, 3, width of the instruction ID carried to execution.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `gc_flush`  in  1  drop buffered instruction and restart clear sequence.
- `dec_valid`  in  1  decode offers an instruction.
- `dec_ready`  out  1  buffer accepts this cycle.
- `dec_rs1_addr`, `dec_rs2_addr`, `dec_rd_addr`  in  5 each  register addresses.
- `dec_uses_rs1`, `dec_uses_rs2`, `dec_uses_rd`  in  1 each  operand-use flags.
- `dec_id`  in  ID_W  instruction ID.
- `rs1_addr`, `rs2_addr`, `rd_inuse_addr`  out  5 each  scoreboard read addresses (from buffer).
- `rs1_inuse`, `rs2_inuse`, `rd_inuse`  in  1 each  scoreboard read data, combinational.
- `retired`, `retired_rd_addr`  in  1 / 5  writeback retire snoop (same signals the scoreboard receives).
- `issued`, `issued_rd_addr`  out  1 / 5  to scoreboard.
- `clr`  out  1  scoreboard clear enable.
- `iss_valid`, `iss_ready`  out / in  1 each  issue handshake to execution.
- `iss_id`, `iss_rd_addr`  out  ID_W / 5  issued instruction fields.
- `init_done`  out  1  high in RUN state.

## Operation
- FSM states: CLEAR, RUN. Reset → CLEAR, clear counter = 0.
- CLEAR: `clr`=1, `dec_ready`=0, `iss_valid`=0. The counter increments each cycle. When the counter reaches CLEAR_CYCLES-1, the FSM goes to RUN and the counter returns to 0.
- RUN: `clr`=0, `init_done`=1. `gc_flush` in any state → CLEAR, counter 0, `buf_valid` ← 0. Flush has priority over accept and fire.
- Buffer: `buf_valid` plus the registered decode fields. Load occurs when `dec_valid && dec_ready`.
- `dec_ready` = RUN && (!buf_valid || fire).
- Per-source hazard `hz_rsN` = uses_rsN && rsN≠0 && rsN_inuse && !(retired && retired_rd_addr==rsN).
- WAW `hz_rd` = uses_rd && rd≠0 && rd_inuse && !(retired && retired_rd_addr==rd).
- `iss_valid` = RUN && buf_valid && !hz_rs1 && !hz_rs2 && !hz_rd.
- fire = `iss_valid && iss_ready`.
- `issued` = fire && uses_rd && rd≠0. Writes to x0 are never marked in use. `issued_rd_addr` = buffered rd.
- `retired` is ignored as a bypass source while in CLEAR.
- Counter width: $clog2(CLEAR_CYCLES).

## Timing
- Reset values: `clr`=1, `init_done`=0, `dec_ready`=0, `iss_valid`=0, `issued`=0, `buf_valid`=0.
- First `dec_ready` occurs CLEAR_CYCLES cycles after `rst` deasserts.
- Accept in cycle N → buffer valid N+1 → earliest fire N+1. Sustained throughput is 1 instruction per cycle with no hazards.
- Scoreboard update from `issued` at N is visible at N+1. A dependent instruction accepted in N therefore sees the hazard at N+1.
- A retire of the blocking rd in cycle M allows fire in cycle M (bypass).
- `iss_valid` may drop without a fire only on `gc_flush`. Otherwise the buffered instruction and its fields stay stable while `iss_valid && !iss_ready`.
- `gc_flush` coincident with `dec_valid`: the instruction is not accepted.
- `gc_flush` coincident with fire: `iss_valid` must be qualified by !gc_flush, so no fire occurs and `issued`=0.

## Test plan
- Reset release with CLEAR_CYCLES=32 → `clr`=1 for exactly 32 cycles, `dec_ready` first high at cycle 32, `init_done` high.
- Back-to-back independent instructions: rd=x1 then rd=x2, `iss_ready`=1 → fires on consecutive cycles, `issued` pulses with addresses 1 and 2.
- RAW: issue rd=x5, next instruction reads rs1=x5 with `rs1_inuse`=1 → `iss_valid`=0 until `retired`=1 with addr 5, then fire in that same cycle.
- WAW and x0: rd=x3 in use → stall until retire of x3. An instruction with rd=x0 fires with `issued`=0.
- Backpressure: `iss_ready`=0 for 4 cycles → `dec_ready`=0 and `iss_id` stable, then fire on the first ready cycle.
- Flush mid-stall: `gc_flush` while buffer holds a stalled instruction → `buf_valid` cleared, `clr`=1 for 32 cycles, no `issued` pulse. Asynchronous `rst` low mid-CLEAR restarts the count at 0.
